// File: rtl/fpga_link_pkg.sv
// Shared state encodings and elaboration-time sizing helpers for the FPGA-to-FPGA word link.
package fpga_link_pkg;

  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_HOLD, T_WAIT_ACK} tx_state_t;
  typedef enum logic {R_COLLECT, R_FULL} rx_state_t;

  function automatic int beats(input int data_w, input int lanes, input int parity_en);
    return data_w / lanes + parity_en;
  endfunction

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/fpga_link_sync.sv
// W-bit two-flop synchroniser for the asynchronous lane, strobe and ack inputs.
module fpga_link_sync #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/fpga_link_serdes.sv
// One end of a toggle-strobe word link: TX serialiser with ack handshake, RX deserialiser with parity.
module fpga_link_serdes
  import fpga_link_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int SETUP_CYC = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              received,
  output logic              parity_err,
  input  logic              processed,
  output logic [LANES-1:0]  tx_lanes,
  output logic              tx_strobe,
  output logic              tx_ack,
  input  logic [LANES-1:0]  rx_lanes,
  input  logic              rx_strobe,
  input  logic              rx_ack
);

  localparam int BEATS = beats(DATA_W, LANES, PARITY_EN);
  localparam int FW    = DATA_W + LANES;
  localparam int BL    = BEATS * LANES;
  localparam int CW    = clog2(SETUP_CYC);
  localparam int BW    = clog2(BEATS);

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  // Word in the low bits, parity beat (lane 0 only) directly above it.
  function automatic logic [FW-1:0] frame_of(input logic [DATA_W-1:0] w);
    logic [FW-1:0] f;
    f = '0;
    f[DATA_W-1:0] = w;
    f[DATA_W] = (PARITY_EN != 0) ? even_parity(w) : 1'b0;
    return f;
  endfunction

  logic [LANES-1:0] lanes_s;
  logic             strobe_s, ack_s, strobe_d, ack_d;
  logic             strobe_edge, ack_edge;

  fpga_link_sync #(.W(LANES + 2)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     ({rx_lanes, rx_strobe, rx_ack}),
    .q     ({lanes_s, strobe_s, ack_s})
  );

  assign strobe_edge = strobe_s ^ strobe_d;
  assign ack_edge    = ack_s ^ ack_d;

  tx_state_t     tx_state;
  logic [FW-1:0] tx_shift;
  logic [FW-1:0] start_frame;
  logic [CW-1:0] tx_cnt;
  logic [BW-1:0] tx_beat;

  assign start_frame = frame_of(data_in);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state  <= T_IDLE;
      busy      <= 1'b0;
      tx_lanes  <= '0;
      tx_strobe <= 1'b0;
      tx_cnt    <= '0;
      tx_beat   <= '0;
    end else begin
      case (tx_state)
        T_IDLE: if (start && !busy) begin
          tx_shift <= start_frame >> LANES;
          tx_lanes <= start_frame[LANES-1:0];
          busy     <= 1'b1;
          tx_cnt   <= '0;
          tx_beat  <= '0;
          tx_state <= T_SETUP;
        end
        T_SETUP: if (tx_cnt == CW'(SETUP_CYC - 1)) begin
          tx_cnt    <= '0;
          tx_strobe <= ~tx_strobe;
          tx_state  <= T_HOLD;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
        T_HOLD: if (tx_cnt == CW'(SETUP_CYC - 1)) begin
          tx_cnt <= '0;
          if (tx_beat == BW'(BEATS - 1)) begin
            tx_lanes <= '0;
            tx_state <= T_WAIT_ACK;
          end else begin
            tx_lanes <= tx_shift[LANES-1:0];
            tx_shift <= tx_shift >> LANES;
            tx_beat  <= tx_beat + 1'b1;
            tx_state <= T_SETUP;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
        T_WAIT_ACK: if (ack_edge) begin
          busy     <= 1'b0;
          tx_state <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  rx_state_t         rx_state;
  logic [BL-1:0]     rx_shift;
  logic [BL-1:0]     rx_next;
  logic [FW-1:0]     rx_frame;
  logic [DATA_W-1:0] rx_word;
  logic [LANES-1:0]  rx_pbeat;
  logic              rx_perr;
  logic [BW-1:0]     rx_beat;

  // New beat enters at the top, so after the last beat the word sits LSB-first at bit 0.
  assign rx_next  = BL'({lanes_s, rx_shift} >> LANES);
  assign rx_frame = FW'(rx_next);
  assign rx_word  = rx_frame[DATA_W-1:0];
  assign rx_pbeat = rx_frame[FW-1:DATA_W];
  assign rx_perr  = (PARITY_EN != 0) &&
                    ((rx_pbeat[0] != even_parity(rx_word)) || ((rx_pbeat >> 1) != '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state   <= R_COLLECT;
      received   <= 1'b0;
      parity_err <= 1'b0;
      data_out   <= '0;
      tx_ack     <= 1'b0;
      rx_beat    <= '0;
      strobe_d   <= 1'b0;
      ack_d      <= 1'b0;
    end else begin
      strobe_d <= strobe_s;
      ack_d    <= ack_s;
      case (rx_state)
        R_COLLECT: if (strobe_edge) begin
          rx_shift <= rx_next;
          if (rx_beat == BW'(BEATS - 1)) begin
            rx_beat    <= '0;
            data_out   <= rx_word;
            parity_err <= rx_perr;
            received   <= 1'b1;
            rx_state   <= R_FULL;
          end else begin
            rx_beat <= rx_beat + 1'b1;
          end
        end
        R_FULL: if (processed) begin
          received   <= 1'b0;
          parity_err <= 1'b0;
          tx_ack     <= ~tx_ack;
          rx_state   <= R_COLLECT;
        end
        default: rx_state <= R_COLLECT;
      endcase
    end
  end

endmodule
